// File: rtl/usb_bus_monitor.sv
// USB full-speed bus monitor: synchronises D+/D-, tracks the bus condition
// (active, bus reset, suspend, resume, remote wakeup) and flags entry events.
module usb_bus_monitor #(
   parameter int unsigned SUSPEND_CYCLES      = 144000,
   parameter int unsigned RESUME_FILTER       = 48,
   parameter int unsigned WAKEUP_HOLDOFF      = 96000,
   parameter int unsigned WAKEUP_DRIVE_CYCLES = 96000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       usb_p_rx,
   input  logic       usb_n_rx,
   input  logic       usb_reset,
   input  logic       remote_wakeup_req,
   output logic [1:0] line_state,
   output logic [2:0] bus_state,
   output logic       suspended,
   output logic       bus_reset_pulse,
   output logic       resume_pulse,
   output logic       wakeup_drive_k
);

   localparam int unsigned CW = 18;
   localparam logic [CW-1:0] IDLE_LAST  = CW'(SUSPEND_CYCLES - 1);
   localparam logic [CW-1:0] KFLT_LAST  = CW'(RESUME_FILTER - 1);
   localparam logic [CW-1:0] HOLD_MAX   = CW'(WAKEUP_HOLDOFF);
   localparam logic [CW-1:0] DRIVE_LAST = CW'(WAKEUP_DRIVE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_ACTIVE    = 3'd0,
      ST_BUS_RESET = 3'd1,
      ST_SUSPEND   = 3'd2,
      ST_RESUME    = 3'd3,
      ST_WAKEUP    = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic            p_meta_q, p_sync_q, n_meta_q, n_sync_q;
   logic [CW-1:0]   idle_q, idle_d;
   logic [CW-1:0]   hold_q, hold_d;
   logic [CW-1:0]   kflt_q, kflt_d;
   logic [CW-1:0]   drive_q, drive_d;
   logic            eop_q, eop_d;
   logic            suspended_q, suspended_d;
   logic            bus_reset_pulse_q, bus_reset_pulse_d;
   logic            resume_pulse_q, resume_pulse_d;
   logic            wakeup_drive_k_q, wakeup_drive_k_d;
   logic            ls_se0, ls_j, ls_k, host_resume;

   assign line_state      = {n_sync_q, p_sync_q};
   assign bus_state       = state_q;
   assign suspended       = suspended_q;
   assign bus_reset_pulse = bus_reset_pulse_q;
   assign resume_pulse    = resume_pulse_q;
   assign wakeup_drive_k  = wakeup_drive_k_q;

   assign ls_se0      = (line_state == 2'b00);
   assign ls_j        = (line_state == 2'b01);
   assign ls_k        = (line_state == 2'b10);
   assign host_resume = ls_k && (kflt_q == KFLT_LAST);

   // Two-flop synchronisers for the asynchronous receiver pins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_meta_q <= 1'b0;
         p_sync_q <= 1'b0;
         n_meta_q <= 1'b0;
         n_sync_q <= 1'b0;
      end else begin
         p_meta_q <= usb_p_rx;
         p_sync_q <= p_meta_q;
         n_meta_q <= usb_n_rx;
         n_sync_q <= n_meta_q;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q           <= ST_ACTIVE;
         idle_q            <= '0;
         hold_q            <= '0;
         kflt_q            <= '0;
         drive_q           <= '0;
         eop_q             <= 1'b0;
         suspended_q       <= 1'b0;
         bus_reset_pulse_q <= 1'b0;
         resume_pulse_q    <= 1'b0;
         wakeup_drive_k_q  <= 1'b0;
      end else begin
         state_q           <= state_d;
         idle_q            <= idle_d;
         hold_q            <= hold_d;
         kflt_q            <= kflt_d;
         drive_q           <= drive_d;
         eop_q             <= eop_d;
         suspended_q       <= suspended_d;
         bus_reset_pulse_q <= bus_reset_pulse_d;
         resume_pulse_q    <= resume_pulse_d;
         wakeup_drive_k_q  <= wakeup_drive_k_d;
      end
   end

   // Next-state, counter updates and output decode; bus reset overrides all
   always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      hold_d  = hold_q;
      kflt_d  = kflt_q;
      drive_d = drive_q;
      eop_d   = eop_q;

      if (usb_reset) begin
         state_d = ST_BUS_RESET;
      end else begin
         case (state_q)
            ST_BUS_RESET: state_d = ST_ACTIVE;
            ST_ACTIVE: begin
               if (!ls_j) begin
                  idle_d = '0;
               end else if (idle_q == IDLE_LAST) begin
                  state_d = ST_SUSPEND;
                  hold_d  = '0;
                  kflt_d  = '0;
               end else begin
                  idle_d = idle_q + CW'(1);
               end
            end
            ST_SUSPEND: begin
               if (hold_q != HOLD_MAX) hold_d = hold_q + CW'(1);
               kflt_d = ls_k ? kflt_q + CW'(1) : '0;
               if (host_resume) begin
                  state_d = ST_RESUME;
                  eop_d   = 1'b0;
               end else if (remote_wakeup_req && (hold_q == HOLD_MAX)) begin
                  state_d = ST_WAKEUP;
                  drive_d = '0;
               end
            end
            ST_WAKEUP: begin
               if (drive_q == DRIVE_LAST) begin
                  state_d = ST_RESUME;
                  eop_d   = 1'b0;
               end else begin
                  drive_d = drive_q + CW'(1);
               end
            end
            ST_RESUME: begin
               if (ls_se0) begin
                  eop_d = 1'b1;
               end else if (ls_j) begin
                  if (eop_q) begin
                     state_d = ST_ACTIVE;
                  end else begin
                     state_d = ST_SUSPEND;
                     hold_d  = '0;
                     kflt_d  = '0;
                  end
               end
            end
            default: state_d = ST_ACTIVE;
         endcase
      end

      // Idle run only means something while active; any other state restarts it
      if (state_q != ST_ACTIVE) idle_d = '0;

      suspended_d       = (state_d == ST_SUSPEND);
      wakeup_drive_k_d  = (state_d == ST_WAKEUP);
      bus_reset_pulse_d = (state_d == ST_BUS_RESET) && (state_q != ST_BUS_RESET);
      resume_pulse_d    = (state_q == ST_SUSPEND) && (state_d == ST_RESUME);
   end

endmodule

// File: tb/tb_usb_bus_monitor.sv
// Self-checking bench for usb_bus_monitor: directed table, corner sequences,
// and randomized segments compared against a per-cycle behavioural model.
module tb_usb_bus_monitor;

   localparam int SC  = 20;
   localparam int RF  = 4;
   localparam int WH  = 10;
   localparam int WDC = 8;

   localparam int S_ACT = 0, S_BR = 1, S_SUS = 2, S_RES = 3, S_WAK = 4;
   localparam int L_SE0 = 0, L_J = 1, L_K = 2;

   logic       clk;
   logic       reset;
   logic       usb_p_rx, usb_n_rx, usb_reset, remote_wakeup_req;
   logic [1:0] line_state;
   logic [2:0] bus_state;
   logic       suspended, bus_reset_pulse, resume_pulse, wakeup_drive_k;

   int checks   = 0;
   int failures = 0;

   usb_bus_monitor #(
      .SUSPEND_CYCLES(SC), .RESUME_FILTER(RF),
      .WAKEUP_HOLDOFF(WH), .WAKEUP_DRIVE_CYCLES(WDC)
   ) dut (
      .clk(clk), .reset(reset),
      .usb_p_rx(usb_p_rx), .usb_n_rx(usb_n_rx),
      .usb_reset(usb_reset), .remote_wakeup_req(remote_wakeup_req),
      .line_state(line_state), .bus_state(bus_state), .suspended(suspended),
      .bus_reset_pulse(bus_reset_pulse), .resume_pulse(resume_pulse),
      .wakeup_drive_k(wakeup_drive_k)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: run lengths and elapsed times per bus condition
   typedef struct {
      int st;
      int jrun;
      int held;
      int krun;
      int drv;
      bit eop;
      bit p1, p2, n1, n2;
      bit brp, rp;
   } model_t;

   model_t m;

   function automatic model_t step(model_t c, bit p, bit n, bit ur, bit wk);
      model_t x;
      int ls;
      x = c;
      ls = int'(c.n2) * 2 + int'(c.p2);
      x.p1 = p; x.p2 = c.p1; x.n1 = n; x.n2 = c.n1;
      if (ur) x.st = S_BR;
      else begin
         case (c.st)
            S_BR: begin x.st = S_ACT; x.jrun = 0; end
            S_ACT: begin
               if (ls != L_J) x.jrun = 0;
               else if (c.jrun + 1 >= SC) begin x.st = S_SUS; x.held = 0; x.krun = 0; end
               else x.jrun = c.jrun + 1;
            end
            S_SUS: begin
               x.held = (c.held < WH) ? c.held + 1 : WH;
               x.krun = (ls == L_K) ? c.krun + 1 : 0;
               if (ls == L_K && c.krun + 1 >= RF) begin x.st = S_RES; x.eop = 0; end
               else if (wk && c.held >= WH) begin x.st = S_WAK; x.drv = 0; end
            end
            S_WAK: begin
               if (c.drv + 1 >= WDC) begin x.st = S_RES; x.eop = 0; end
               else x.drv = c.drv + 1;
            end
            S_RES: begin
               if (ls == L_SE0) x.eop = 1;
               else if (ls == L_J) begin
                  if (c.eop) begin x.st = S_ACT; x.jrun = 0; end
                  else begin x.st = S_SUS; x.held = 0; x.krun = 0; end
               end
            end
            default: x.st = S_ACT;
         endcase
      end
      x.brp = (x.st == S_BR) && (c.st != S_BR);
      x.rp  = (c.st == S_SUS) && (x.st == S_RES);
      return x;
   endfunction

   // Advance the model on the same edges the DUT sees
   always @(posedge clk or posedge reset) begin
      if (reset) m <= '{default: 0};
      else m <= step(m, usb_p_rx, usb_n_rx, usb_reset, remote_wakeup_req);
   end

   // Continuous comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (!reset) begin
         chk("m_bus_state", int'(bus_state), m.st);
         chk("m_line_state", int'(line_state), int'(m.n2) * 2 + int'(m.p2));
         chk("m_suspended", int'(suspended), int'(m.st == S_SUS));
         chk("m_drive_k", int'(wakeup_drive_k), int'(m.st == S_WAK));
         chk("m_bus_reset_pulse", int'(bus_reset_pulse), int'(m.brp));
         chk("m_resume_pulse", int'(resume_pulse), int'(m.rp));
      end
   end

   task automatic drive(input bit p, input bit n, input bit ur, input bit wk, input int cycles);
      usb_p_rx = p; usb_n_rx = n; usb_reset = ur; remote_wakeup_req = wk;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic get_suspend();
      int n = 0;
      usb_p_rx = 1'b1; usb_n_rx = 1'b0; usb_reset = 1'b0; remote_wakeup_req = 1'b0;
      while (!suspended && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("suspend_reached", int'(suspended), 1);
   endtask

   task automatic wait_wakeup();
      get_suspend();
      repeat (WH) @(posedge clk);
      #1 remote_wakeup_req = 1'b1;
      @(posedge clk);
      #1 remote_wakeup_req = 1'b0;
      chk("wakeup_entered", int'(bus_state), S_WAK);
   endtask

   typedef struct {
      bit p, n, ur, wk;
      int cyc;
      int exp_st;
   } vec_t;

   vec_t tbl[20];

   initial begin
      int cnt, guard;
      tbl[0]  = '{1, 0, 0, 0, 10, S_ACT};
      tbl[1]  = '{0, 1, 0, 0, 1,  S_ACT};
      tbl[2]  = '{1, 0, 0, 0, 15, S_ACT};
      tbl[3]  = '{1, 0, 0, 0, 10, S_SUS};
      tbl[4]  = '{1, 0, 0, 0, 12, S_SUS};
      tbl[5]  = '{0, 1, 0, 0, 2,  S_SUS};
      tbl[6]  = '{1, 0, 0, 0, 3,  S_SUS};
      tbl[7]  = '{0, 1, 0, 0, 8,  S_RES};
      tbl[8]  = '{0, 0, 0, 0, 3,  S_RES};
      tbl[9]  = '{1, 0, 0, 0, 5,  S_ACT};
      tbl[10] = '{1, 0, 0, 0, 25, S_SUS};
      tbl[11] = '{1, 0, 0, 1, 1,  S_SUS};
      tbl[12] = '{1, 0, 0, 0, 20, S_SUS};
      tbl[13] = '{1, 0, 0, 1, 1,  S_WAK};
      tbl[14] = '{1, 0, 0, 0, 4,  S_WAK};
      tbl[15] = '{1, 0, 0, 0, 10, S_SUS};
      tbl[16] = '{1, 0, 1, 0, 5,  S_BR};
      tbl[17] = '{1, 0, 0, 0, 2,  S_ACT};
      tbl[18] = '{1, 1, 0, 0, 5,  S_ACT};
      tbl[19] = '{1, 0, 0, 0, 3,  S_ACT};

      reset = 1'b0;
      usb_p_rx = 1'b0; usb_n_rx = 1'b0; usb_reset = 1'b0; remote_wakeup_req = 1'b0;
      #1 reset = 1'b1;
      #2;
      chk("rst_bus_state", int'(bus_state), S_ACT);
      chk("rst_line_state", int'(line_state), 0);
      chk("rst_outputs", int'({suspended, bus_reset_pulse, resume_pulse, wakeup_drive_k}), 0);
      #19 reset = 1'b0;
      @(posedge clk);
      #1;

      // Directed table
      foreach (tbl[i]) begin
         drive(tbl[i].p, tbl[i].n, tbl[i].ur, tbl[i].wk, tbl[i].cyc);
         chk($sformatf("tbl%0d_state", i), int'(bus_state), tbl[i].exp_st);
         chk($sformatf("tbl%0d_susp", i), int'(suspended), int'(tbl[i].exp_st == S_SUS));
         chk($sformatf("tbl%0d_drvk", i), int'(wakeup_drive_k), int'(tbl[i].exp_st == S_WAK));
      end

      // Holdoff boundary: one cycle early is dropped, on time is taken
      get_suspend();
      repeat (WH - 1) @(posedge clk);
      #1 remote_wakeup_req = 1'b1;
      @(posedge clk);
      #1 chk("early_wake_dropped", int'(bus_state), S_SUS);
      @(posedge clk);
      #1 remote_wakeup_req = 1'b0;
      chk("wake_on_time", int'(bus_state), S_WAK);
      cnt = 1; guard = 0;
      while (wakeup_drive_k && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
         if (wakeup_drive_k) cnt++;
      end
      chk("drive_k_cycles", cnt, WDC);
      chk("after_wake_state", int'(bus_state), S_RES);
      chk("after_wake_no_rpulse", int'(resume_pulse), 0);

      // Host resume qualifying together with a wakeup request wins
      drive(1, 0, 0, 0, 30);
      usb_p_rx = 1'b0; usb_n_rx = 1'b1;
      repeat (RF + 1) @(posedge clk);
      #1 remote_wakeup_req = 1'b1;
      @(posedge clk);
      #1 remote_wakeup_req = 1'b0;
      chk("tie_state", int'(bus_state), S_RES);
      chk("tie_rpulse", int'(resume_pulse), 1);
      chk("tie_drvk", int'(wakeup_drive_k), 0);
      @(posedge clk);
      #1 chk("tie_rpulse_once", int'(resume_pulse), 0);
      drive(0, 0, 0, 0, 3);
      drive(1, 0, 0, 0, 4);
      chk("eop_to_active", int'(bus_state), S_ACT);

      // Held bus reset from SUSPEND gives one pulse
      get_suspend();
      usb_reset = 1'b1;
      cnt = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (bus_reset_pulse) cnt++;
      end
      chk("susp_reset_pulses", cnt, 1);
      chk("susp_reset_state", int'(bus_state), S_BR);
      usb_reset = 1'b0;
      @(posedge clk);
      #1 chk("susp_reset_release", int'(bus_state), S_ACT);

      // Bus reset during WAKEUP drops K the next cycle
      wait_wakeup();
      usb_reset = 1'b1;
      @(posedge clk);
      #1 chk("wak_reset_drvk", int'(wakeup_drive_k), 0);
      chk("wak_reset_pulse", int'(bus_reset_pulse), 1);
      cnt = 0;
      repeat (50) begin
         @(posedge clk);
         #1;
         if (bus_reset_pulse) cnt++;
      end
      chk("wak_reset_pulse_once", cnt, 0);
      usb_reset = 1'b0;
      @(posedge clk);
      #1 chk("wak_reset_release", int'(bus_state), S_ACT);

      // Asynchronous reset in the middle of WAKEUP
      wait_wakeup();
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("async_rst_state", int'(bus_state), S_ACT);
      chk("async_rst_outputs", int'({line_state, suspended, bus_reset_pulse, resume_pulse, wakeup_drive_k}), 0);
      @(negedge clk);
      #2 reset = 1'b0;
      @(posedge clk);
      #1;

      // Randomized line segments with sporadic wakeup requests and bus resets
      for (int s = 0; s < 260; s++) begin
         int r, len;
         bit p, n, ur;
         r = int'($urandom_range(0, 99));
         ur = 1'b0;
         if (r < 55)      begin p = 1; n = 0; end
         else if (r < 75) begin p = 0; n = 1; end
         else if (r < 88) begin p = 0; n = 0; end
         else             begin p = 1; n = 1; end
         if ($urandom_range(0, 99) < 3) ur = 1'b1;
         len = ur ? int'($urandom_range(1, 5)) : int'($urandom_range(1, 30));
         for (int c = 0; c < len; c++)
            drive(p, n, ur, ($urandom_range(0, 15) == 0), 1);
      end
      drive(1, 0, 0, 0, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/usb_bus_monitor.md
USB_BUS_MONITOR -- requirements
Module: usb_bus_monitor

Interface
REQ-001 Parameter SUSPEND_CYCLES, default 144000, consecutive idle-J cycles before suspend (3 ms at 48 MHz).
REQ-002 Parameter RESUME_FILTER, default 48, consecutive K cycles in SUSPEND that qualify as host resume.
REQ-003 Parameter WAKEUP_HOLDOFF, default 96000, cycles in SUSPEND before remote wakeup is accepted.
REQ-004 Parameter WAKEUP_DRIVE_CYCLES, default 96000, cycles K is driven for remote wakeup.
REQ-005 All parameters SHALL be in 1..2^18-1; all counters SHALL be 18 bits.
REQ-006 clk  in  1  single system clock (48 MHz nominal).
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 usb_p_rx  in  1  raw D+ receiver output, asynchronous to clk.
REQ-009 usb_n_rx  in  1  raw D- receiver output, asynchronous to clk.
REQ-010 usb_reset  in  1  level bus-reset indication from the reset detector, synchronous to clk.
REQ-011 remote_wakeup_req  in  1  one-cycle remote wakeup request.
REQ-012 line_state  out  2  synchronized {n,p}: 00 SE0, 01 J, 10 K, 11 SE1.
REQ-013 bus_state  out  3  0 ACTIVE, 1 BUS_RESET, 2 SUSPEND, 3 RESUME, 4 WAKEUP.
REQ-014 suspended  out  1  high exactly while bus_state == SUSPEND.
REQ-015 bus_reset_pulse  out  1  one-cycle pulse on BUS_RESET entry.
REQ-016 resume_pulse  out  1  one-cycle pulse on RESUME entry from SUSPEND (host-initiated only).
REQ-017 wakeup_drive_k  out  1  request to transmitter to drive K; high exactly while bus_state == WAKEUP.

Function
REQ-018 p and n SHALL each pass a two-flop synchronizer; line_state lags pins by 2 cycles; all decisions use line_state.
REQ-019 usb_reset high SHALL force BUS_RESET next cycle from any state; this has highest priority.
REQ-020 bus_reset_pulse SHALL assert for the cycle state first equals BUS_RESET; a held usb_reset gives one pulse.
REQ-021 BUS_RESET -> ACTIVE the cycle after usb_reset is low; idle counter cleared.
REQ-022 ACTIVE: idle counter increments on each J cycle, clears on any non-J (SE0, K, SE1).
REQ-023 ACTIVE: J with idle counter == SUSPEND_CYCLES-1 -> SUSPEND next cycle (SUSPEND_CYCLES-th consecutive J).
REQ-024 SUSPEND entry SHALL clear holdoff and K-filter counters; holdoff counter increments each cycle, saturating at WAKEUP_HOLDOFF.
REQ-025 SUSPEND: K-filter counter increments on K, clears on non-K; K with counter == RESUME_FILTER-1 -> RESUME, resume_pulse in the first RESUME cycle.
REQ-026 SUSPEND: remote_wakeup_req with holdoff counter == WAKEUP_HOLDOFF -> WAKEUP; requests earlier, or in any other state, SHALL be dropped, not queued.
REQ-027 Host resume qualifying in the same cycle as remote_wakeup_req SHALL win: RESUME entered, request dropped.
REQ-028 WAKEUP: drive counter counts WAKEUP_DRIVE_CYCLES cycles, then -> RESUME with wakeup_drive_k low; no resume_pulse; line_state ignored.
REQ-029 RESUME: SE0 sets an eop_seen flag; J with eop_seen -> ACTIVE (idle counter cleared); J without eop_seen -> SUSPEND (false resume); K/SE1 hold.
REQ-030 usb_reset during WAKEUP SHALL drop wakeup_drive_k the next cycle.

Reset
REQ-031 On reset: bus_state ACTIVE, synchronizer flops 0 (line_state 00), all counters and eop_seen 0, all pulse/level outputs 0.
REQ-032 Reset release SHALL need no clocking before the first J is counted.

Verification
REQ-033 Reset, then hold J 144000 cycles -> suspended rises on the 144000th J cycle after line_state shows J; one K at cycle 100000 restarts the count.
REQ-034 In SUSPEND, 47 K cycles then J -> stays SUSPEND; 48 K cycles -> resume_pulse once, bus_state 3; then SE0, J -> bus_state 0.
REQ-035 In SUSPEND, remote_wakeup_req at 95999 cycles -> ignored; at 96000 -> wakeup_drive_k high exactly 96000 cycles, then bus_state 3.
REQ-036 usb_reset held 1000 cycles from SUSPEND and from WAKEUP -> one bus_reset_pulse, wakeup_drive_k low next cycle, ACTIVE after release.
REQ-037 Same-cycle 48th K and remote_wakeup_req -> RESUME with resume_pulse, wakeup_drive_k stays 0.
REQ-038 Assert reset mid-WAKEUP -> all outputs 0 immediately (asynchronous), bus_state 0.
